// File: rtl/instr_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package instr_fetch_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] DEF_RESET_PC = 32'd0;
  localparam logic [PC_W-1:0] DEF_PC_STEP  = 32'd4;
  localparam logic [PC_W-1:0] DEF_PROG_END = 32'd20;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DONE  = 1'b1
  } fetch_state_e;

  // Branch targets are forced onto a word boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_pc_gen.sv
// Next-PC selection: reset, branch redirect, sequential increment or hold.
module instr_fetch_pc_gen
  import instr_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [PC_W-1:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic            reset_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            advance_i,
  input  logic [PC_W-1:0] pc_q_i,
  output logic [PC_W-1:0] pc_d_o
);

  always_comb begin
    pc_d_o = pc_q_i;
    if (reset_i) begin
      pc_d_o = RESET_PC;
    end else if (redirect_i) begin
      pc_d_o = align_pc(redirect_pc_i);
    end else if (advance_i) begin
      // Wraps modulo 2^32 by construction.
      pc_d_o = pc_q_i + PC_STEP;
    end else begin
      pc_d_o = pc_q_i;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, instruction-memory address, registered fetch slot
// toward decode with branch redirect and end-of-program halt.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [PC_W-1:0] PC_STEP  = DEF_PC_STEP,
  parameter logic [PC_W-1:0] PROG_END = DEF_PROG_END
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic               fetch_done
);

  fetch_state_e        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                id_valid_q, id_valid_d;
  logic [INSTR_W-1:0]  id_instr_q, id_instr_d;
  logic [PC_W-1:0]     id_pc_q, id_pc_d;
  logic                fetch_done_q, fetch_done_d;
  logic                slot_free_s;
  logic                advance_s;

  assign slot_free_s = !id_valid_q || id_ready;

  instr_fetch_pc_gen #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_gen (
    .reset_i       (reset),
    .redirect_i    (redirect_valid),
    .redirect_pc_i (redirect_pc),
    .advance_i     (advance_s),
    .pc_q_i        (pc_q),
    .pc_d_o        (pc_d)
  );

  always_comb begin
    state_d    = state_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    advance_s  = 1'b0;
    if (redirect_valid) begin
      // The in-flight slot is squashed even if decode is taking it.
      state_d    = ST_FETCH;
      id_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (pc_q >= PROG_END) begin
            state_d    = ST_DONE;
            id_valid_d = id_valid_q && !id_ready;
          end else if (slot_free_s) begin
            advance_s  = 1'b1;
            id_valid_d = 1'b1;
            id_instr_d = mem_instr;
            id_pc_d    = pc_q;
          end else begin
            id_valid_d = id_valid_q;
          end
        end
        ST_DONE: begin
          id_valid_d = id_valid_q && !id_ready;
        end
        default: begin
          state_d    = ST_FETCH;
          id_valid_d = 1'b0;
        end
      endcase
    end
    fetch_done_d = (state_d == ST_DONE) && !id_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_instr_q   <= {INSTR_W{1'b0}};
      id_pc_q      <= {PC_W{1'b0}};
      fetch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      fetch_done_q <= fetch_done_d;
    end
  end

  assign mem_addr   = pc_q;
  assign id_valid   = id_valid_q;
  assign id_instr   = id_instr_q;
  assign id_pc      = id_pc_q;
  assign fetch_done = fetch_done_q;

endmodule
